// File: rtl/uart_rcv_pkg.sv
// Shared state/parity encodings and lower bounds for the UART receive path.
package uart_rcv_pkg;

    localparam int unsigned MIN_DATA_BITS  = 5;
    localparam int unsigned MIN_BIT_PERIOD = 4;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StPush
    } rcv_state_e;

    typedef enum logic [1:0] {
        ParNone,
        ParEven,
        ParOdd,
        ParRsvd
    } parity_mode_e;

endpackage

// File: rtl/rcv_fifo_buf.sv
// Synchronous FIFO with a registered head word; the head reads as zero while empty.
module rcv_fifo_buf #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push, do_pop;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign head  = head_q;

    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        rd_d    = rd_q + AW'(do_pop);
        wr_d    = wr_q + AW'(do_push);
        cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
        // Once every old entry is gone, the new head can only be the incoming word.
        if (cnt_d == '0) begin
            head_d = '0;
        end else if (cnt_q == CW'(do_pop)) begin
            head_d = wdata;
        end else begin
            head_d = mem[rd_d];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            head_q <= '0;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
        end
    end

endmodule

// File: rtl/uart_rcv_fifo.sv
// UART receiver: synchroniser, glitch-rejecting start detect, mid-bit sampling and receive FIFO.
// Define UART_RCV_PARITY_EN for the optional parity bit (parity_mode in, parity_error out).
module uart_rcv_fifo
    import uart_rcv_pkg::*;
#(
    parameter int unsigned MAX_DATA_BITS = 8,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned BP_W          = 14
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          serial_in,
    input  logic [BP_W-1:0]               bit_period,
    input  logic [3:0]                    data_size,
    input  logic                          data_read,
`ifdef UART_RCV_PARITY_EN
    input  logic [1:0]                    parity_mode,
    output logic                          parity_error,
`endif
    output logic [MAX_DATA_BITS-1:0]      rx_data,
    output logic                          data_ready,
    output logic                          framing_error,
    output logic                          overrun_error,
    output logic                          rx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
`ifdef UART_RCV_PARITY_EN
    localparam int unsigned FLAG_W = 2;
`else
    localparam int unsigned FLAG_W = 1;
`endif
    localparam int unsigned ENTRY_W = MAX_DATA_BITS + FLAG_W;

    rcv_state_e               state_q, state_d;
    logic                     sync1_q, sync2_q, line_d_q, line_s, fall;
    logic [BP_W-1:0]          cnt_q, cnt_d, bp_q, bp_d, bp_eff;
    logic [3:0]               ds_q, ds_d, ds_eff, idx_q, idx_d;
    logic [MAX_DATA_BITS-1:0] word_q, word_d;
    logic                     ferr_q, ferr_d, expired, use_par;
    logic                     push, pop, full, empty, overrun_q, overrun_d;
    logic [ENTRY_W-1:0]       wdata, head;
`ifdef UART_RCV_PARITY_EN
    parity_mode_e             par_q, par_d;
    logic                     perr_q, perr_d;

    assign use_par      = (par_q == ParEven) || (par_q == ParOdd);
    assign wdata        = {word_q, ferr_q, perr_q};
    assign parity_error = head[0];
`else
    assign use_par      = 1'b0;
    assign wdata        = {word_q, ferr_q};
`endif

    assign line_s        = sync2_q;
    assign fall          = line_d_q & ~line_s;
    assign expired       = (cnt_q == BP_W'(1));
    assign rx_data       = head[ENTRY_W-1 -: MAX_DATA_BITS];
    assign framing_error = head[FLAG_W-1];
    assign data_ready    = ~empty;
    assign rx_busy       = (state_q != StIdle);
    assign overrun_error = overrun_q;
    assign pop           = data_read & ~empty;

    always_comb begin
        bp_eff = (bit_period < BP_W'(MIN_BIT_PERIOD)) ? BP_W'(MIN_BIT_PERIOD) : bit_period;
        if (data_size < 4'(MIN_DATA_BITS)) begin
            ds_eff = 4'(MIN_DATA_BITS);
        end else if (data_size > 4'(MAX_DATA_BITS)) begin
            ds_eff = 4'(MAX_DATA_BITS);
        end else begin
            ds_eff = data_size;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bp_d    = bp_q;
        ds_d    = ds_q;
        idx_d   = idx_q;
        word_d  = word_q;
        ferr_d  = ferr_q;
        push    = 1'b0;
`ifdef UART_RCV_PARITY_EN
        par_d   = par_q;
        perr_d  = perr_q;
`endif
        if (state_q != StIdle && state_q != StPush && !expired) begin
            cnt_d = cnt_q - BP_W'(1);
        end
        unique case (state_q)
            StIdle: begin
                if (fall) begin
                    bp_d    = bp_eff;
                    ds_d    = ds_eff;
                    cnt_d   = bp_eff >> 1;
                    idx_d   = '0;
                    word_d  = '0;
                    ferr_d  = 1'b0;
`ifdef UART_RCV_PARITY_EN
                    par_d   = parity_mode_e'(parity_mode);
                    perr_d  = 1'b0;
`endif
                    state_d = StStart;
                end
            end
            StStart: begin
                if (expired) begin
                    cnt_d   = bp_q;
                    state_d = line_s ? StIdle : StData;
                end
            end
            StData: begin
                if (expired) begin
                    cnt_d = bp_q;
                    for (int unsigned i = 0; i < MAX_DATA_BITS; i++) begin
                        if (i == 32'(idx_q)) begin
                            word_d[i] = line_s;
                        end
                    end
                    if (idx_q == ds_q - 4'd1) begin
                        state_d = use_par ? StParity : StStop;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
`ifdef UART_RCV_PARITY_EN
            StParity: begin
                if (expired) begin
                    cnt_d   = bp_q;
                    // Even mode flags an odd total of ones; odd mode the reverse.
                    perr_d  = (^word_q ^ line_s) ^ (par_q == ParOdd);
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                if (expired) begin
                    ferr_d  = ~line_s;
                    state_d = StPush;
                end
            end
            StPush: begin
                push    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // A simultaneous pop frees the slot, so only push-on-full without a read drops the word.
    always_comb begin
        if (push && full && !data_read) begin
            overrun_d = 1'b1;
        end else if (pop) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            line_d_q  <= 1'b1;
            state_q   <= StIdle;
            cnt_q     <= '0;
            bp_q      <= '0;
            ds_q      <= '0;
            idx_q     <= '0;
            word_q    <= '0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef UART_RCV_PARITY_EN
            par_q     <= ParNone;
            perr_q    <= 1'b0;
`endif
        end else begin
            sync1_q   <= serial_in;
            sync2_q   <= sync1_q;
            line_d_q  <= sync2_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bp_q      <= bp_d;
            ds_q      <= ds_d;
            idx_q     <= idx_d;
            word_q    <= word_d;
            ferr_q    <= ferr_d;
            overrun_q <= overrun_d;
`ifdef UART_RCV_PARITY_EN
            par_q     <= par_d;
            perr_q    <= perr_d;
`endif
        end
    end

    rcv_fifo_buf #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .full  (full),
        .empty (empty),
        .count (fifo_count),
        .head  (head)
    );

endmodule
